// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RISC-V M-extension unit. Fixed-latency multiplier and
// radix-2 restoring divider sequenced by an IDLE/MUL/DIV/DONE controller.
module ex_muldiv #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_funct3,
  input  logic [4:0]      req_rd,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            busy,
  output logic            pause_signal,
  output logic            unpause_signal,
  output logic            resp_valid,
  output logic [4:0]      resp_rd,
  output logic [XLEN-1:0] resp_data
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, data_q, data_d;
  logic            negq_q, negq_d, negr_q, negr_d, fix_q, fix_d;

  logic            accept, div_signed, op1_neg, op2_neg, div_zero, div_ovf;
  logic            ma_s, mb_s;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] quo_res, rem_res;

  assign accept     = (state_q == IDLE) && req_valid && !flush;
  assign div_signed = ~req_funct3[0];
  assign op1_neg    = div_signed & operand1[XLEN-1];
  assign op2_neg    = div_signed & operand2[XLEN-1];
  assign div_zero   = (operand2 == '0);
  assign div_ovf    = div_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);

  // Extension by funct3: MUL/MULH both signed, MULHSU rs1 only, MULHU neither.
  assign ma_s = (f3_q[1:0] != 2'b11) & a_q[XLEN-1];
  assign mb_s = ~f3_q[1] & b_q[XLEN-1];
  assign prod = {{XLEN{ma_s}}, a_q} * {{XLEN{mb_s}}, b_q};

  // a_q doubles as the dividend/quotient shift register while dividing.
  assign rem_sh  = {rem_q, a_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, b_q};
  assign quo_res = negq_q ? (~a_q + XLEN'(1)) : a_q;
  assign rem_res = negr_q ? (~rem_q + XLEN'(1)) : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    data_d  = data_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    fix_d   = fix_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d   = req_funct3;
          rd_d   = req_rd;
          a_d    = operand1;
          b_d    = operand2;
          rem_d  = '0;
          negq_d = 1'b0;
          negr_d = 1'b0;
          fix_d  = 1'b0;
          if (!req_funct3[2]) begin
            state_d = MUL;
            cnt_d   = CW'(MUL_LAT - 1);
          end else begin
            state_d = DIV;
            cnt_d   = CW'(XLEN - 1);
            // Fast paths preload quotient/remainder and skip straight to the fix edge.
            if (div_zero) begin
              a_d   = '1;
              rem_d = operand1;
              fix_d = 1'b1;
            end else if (div_ovf) begin
              fix_d = 1'b1;
            end else begin
              a_d    = op1_neg ? (~operand1 + XLEN'(1)) : operand1;
              b_d    = op2_neg ? (~operand2 + XLEN'(1)) : operand2;
              negq_d = op1_neg ^ op2_neg;
              negr_d = op1_neg;
            end
          end
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          data_d  = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV: begin
        if (fix_q) begin
          state_d = DONE;
          fix_d   = 1'b0;
          data_d  = f3_q[1] ? rem_res : quo_res;
        end else begin
          a_d   = {a_q[XLEN-2:0], ~diff[XLEN]};
          rem_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          if (cnt_q == '0) fix_d = 1'b1;
          else             cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      fix_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      fix_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      fix_q   <= fix_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign resp_valid     = (state_q == DONE) && !flush;
  assign unpause_signal = resp_valid;
  // Hold the issuing instruction in EX from the cycle it is presented.
  assign pause_signal   = busy | (rst & (state_q == IDLE) & req_valid & ~flush);
  assign resp_rd        = rd_q;
  assign resp_data      = data_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv: table of directed vectors on a 32-bit/MUL_LAT=2 and a
// 64-bit/MUL_LAT=4 instance, plus flush and reset sequences.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst, v32, v64, flush;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [63:0] a, b;

  logic        busy32, pause32, unp32, rv32;
  logic [4:0]  rrd32;
  logic [31:0] d32;
  logic        busy64, pause64, unp64, rv64;
  logic [4:0]  rrd64;
  logic [63:0] d64;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .MUL_LAT(2)) u32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_funct3(f3), .req_rd(rd),
    .operand1(a[31:0]), .operand2(b[31:0]), .flush(flush),
    .busy(busy32), .pause_signal(pause32), .unpause_signal(unp32),
    .resp_valid(rv32), .resp_rd(rrd32), .resp_data(d32)
  );

  ex_muldiv #(.XLEN(64), .MUL_LAT(4)) u64 (
    .clk(clk), .rst(rst), .req_valid(v64), .req_funct3(f3), .req_rd(rd),
    .operand1(a), .operand2(b), .flush(flush),
    .busy(busy64), .pause_signal(pause64), .unpause_signal(unp64),
    .resp_valid(rv64), .resp_rd(rrd64), .resp_data(d64)
  );

  typedef struct {
    bit          w;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    int          n;
  } vec_t;

  vec_t vecs[$];
  int   passed, total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic obs_rv(bit w);    return w ? rv64 : rv32;       endfunction
  function automatic logic obs_busy(bit w);  return w ? busy64 : busy32;   endfunction
  function automatic logic obs_pause(bit w); return w ? pause64 : pause32; endfunction
  function automatic logic [5:0] obs_rd(bit w);
    return w ? {unp64, rrd64} : {unp32, rrd32};
  endfunction
  function automatic logic [63:0] obs_data(bit w);
    return w ? d64 : {32'h0, d32};
  endfunction

  // Called at a falling edge; returns at a falling edge.
  task automatic run_op(input vec_t t, input int id);
    int          got;
    logic [63:0] gd;
    logic [5:0]  grd;
    logic        p0;
    f3 = t.f3; a = t.a; b = t.b; rd = t.rd;
    if (t.w) v64 = 1'b1; else v32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v32 = 1'b0; v64 = 1'b0;
    p0  = obs_pause(t.w);
    got = -1; gd = '0; grd = '0;
    for (int k = 0; k <= 100 && got < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (obs_rv(t.w)) begin
        got = k;
        gd  = obs_data(t.w);
        grd = obs_rd(t.w);
      end
    end
    check($sformatf("pause_after_accept[%0d]", id), 64'(p0), 64'd1);
    check($sformatf("latency[%0d]", id), 64'(got), 64'(t.n));
    check($sformatf("data[%0d]", id), gd, t.exp);
    check($sformatf("unpause_rd[%0d]", id), 64'(grd), {58'h0, 1'b1, t.rd});
    @(negedge clk);
    check($sformatf("idle_after[%0d]", id),
          64'({obs_busy(t.w), obs_pause(t.w), obs_rv(t.w)}), 64'd0);
  endtask

  logic any;

  initial begin
    passed = 0; total = 0;
    rst = 1'b0; v32 = 1'b0; v64 = 1'b0; flush = 1'b0;
    f3 = '0; rd = '0; a = '0; b = '0;

    vecs.push_back('{1'b0, 3'b000, 64'd7,         64'hFFFFFFFD, 5'd1,  64'hFFFFFFEB, 2});
    vecs.push_back('{1'b0, 3'b001, 64'h80000000,  64'h80000000, 5'd2,  64'h40000000, 2});
    vecs.push_back('{1'b0, 3'b010, 64'hFFFFFFFF,  64'hFFFFFFFF, 5'd3,  64'hFFFFFFFF, 2});
    vecs.push_back('{1'b0, 3'b011, 64'hFFFFFFFF,  64'hFFFFFFFF, 5'd4,  64'hFFFFFFFE, 2});
    vecs.push_back('{1'b0, 3'b000, 64'h12345678,  64'h10,       5'd5,  64'h23456780, 2});
    vecs.push_back('{1'b0, 3'b100, 64'hFFFFFFF9,  64'd2,        5'd6,  64'hFFFFFFFD, 33});
    vecs.push_back('{1'b0, 3'b110, 64'hFFFFFFF9,  64'd2,        5'd7,  64'hFFFFFFFF, 33});
    vecs.push_back('{1'b0, 3'b101, 64'd100,       64'd7,        5'd8,  64'd14,       33});
    vecs.push_back('{1'b0, 3'b111, 64'd100,       64'd7,        5'd9,  64'd2,        33});
    vecs.push_back('{1'b0, 3'b100, 64'hFFFFFF9C,  64'd7,        5'd10, 64'hFFFFFFF2, 33});
    vecs.push_back('{1'b0, 3'b110, 64'hFFFFFF9C,  64'd7,        5'd11, 64'hFFFFFFFE, 33});
    vecs.push_back('{1'b0, 3'b100, 64'd100,       64'hFFFFFFF9, 5'd12, 64'hFFFFFFF2, 33});
    vecs.push_back('{1'b0, 3'b110, 64'd100,       64'hFFFFFFF9, 5'd13, 64'd2,        33});
    vecs.push_back('{1'b0, 3'b101, 64'd5,         64'd0,        5'd14, 64'hFFFFFFFF, 1});
    vecs.push_back('{1'b0, 3'b110, 64'd5,         64'd0,        5'd15, 64'd5,        1});
    vecs.push_back('{1'b0, 3'b100, 64'h80000000,  64'hFFFFFFFF, 5'd16, 64'h80000000, 1});
    vecs.push_back('{1'b0, 3'b110, 64'h80000000,  64'hFFFFFFFF, 5'd0,  64'd0,        1});
    vecs.push_back('{1'b1, 3'b100, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd20, 64'hFFFFFFFFFFFFFFFD, 65});
    vecs.push_back('{1'b1, 3'b110, 64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd21, 64'hFFFFFFFFFFFFFFFF, 65});
    vecs.push_back('{1'b1, 3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd22,
                     64'hFFFFFFFFFFFFFFFE, 4});
    vecs.push_back('{1'b1, 3'b000, 64'd7, 64'hFFFFFFFFFFFFFFFD, 5'd23, 64'hFFFFFFFFFFFFFFEB, 4});
    vecs.push_back('{1'b1, 3'b101, 64'd5, 64'd0,                5'd24, 64'hFFFFFFFFFFFFFFFF, 1});

    repeat (2) @(negedge clk);
    check("reset_out32", 64'({busy32, pause32, unp32, rv32, rrd32, d32}), 64'd0);
    check("reset_out64", 64'({busy64, pause64, unp64, rv64, rrd64}), 64'd0);
    check("reset_data64", d64, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_out32", 64'({busy32, pause32, unp32, rv32, rrd32, d32}), 64'd0);

    foreach (vecs[i]) run_op(vecs[i], i);

    // Flush taking effect at edge 10 of a divide, then a MUL accepted at edge 11.
    f3 = 3'b100; a = 64'd100; b = 64'd7; rd = 5'd9; v32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v32 = 1'b0; any = rv32;
    repeat (9) begin
      @(negedge clk);
      any |= rv32;
    end
    flush = 1'b1;
    @(negedge clk);
    any |= rv32;
    flush = 1'b0;
    check("flush_busy", 64'(busy32), 64'd0);
    run_op('{1'b0, 3'b000, 64'd6, 64'd7, 5'd3, 64'd42, 2}, 100);
    check("flush_no_resp", 64'(any), 64'd0);

    // Flush together with a request in IDLE drops the request.
    f3 = 3'b000; a = 64'd3; b = 64'd4; rd = 5'd5; v32 = 1'b1; flush = 1'b1;
    #1;
    check("flush_req_pause", 64'(pause32), 64'd0);
    @(posedge clk);
    @(negedge clk);
    v32 = 1'b0; flush = 1'b0;
    check("flush_req_busy", 64'(busy32), 64'd0);
    any = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any |= rv32;
    end
    check("flush_req_no_resp", 64'(any), 64'd0);

    // Reset asserted just after edge 5 of a divide.
    f3 = 3'b100; a = 64'hFFFFFFF9; b = 64'd2; rd = 5'd17; v32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v32 = 1'b0;
    repeat (5) @(posedge clk);
    check("busy_before_reset", 64'(busy32), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_reset_out32", 64'({busy32, pause32, unp32, rv32, rrd32, d32}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op('{1'b0, 3'b100, 64'hFFFFFFF9, 64'd2, 5'd17, 64'hFFFFFFFD, 33}, 101);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
